// File: rtl/heap_pq_pkg.sv
// Shared encodings for the heap priority-queue functional unit.
package heap_pq_pkg;

    localparam logic [1:0] OP_PUSH  = 2'd0;
    localparam logic [1:0] OP_POP   = 2'd1;
    localparam logic [1:0] OP_PEEK  = 2'd2;
    localparam logic [1:0] OP_CLEAR = 2'd3;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        SIFT_UP   = 2'd1,
        SIFT_DOWN = 2'd2
    } state_t;

endpackage

// File: rtl/heap_pq_cmp.sv
// Unsigned key comparator: a_wins is strict greater-than (max-heap) or strict less-than (min-heap).
module heap_pq_cmp #(
    parameter int DATA_W   = 32,
    parameter int MIN_HEAP = 0
) (
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic              a_wins
);

    assign a_wins = (MIN_HEAP != 0) ? (a < b) : (a > b);

endmodule

// File: rtl/heap_pq_unit.sv
// Binary-heap priority queue with push/pop/peek/clear commands and a fixed one-cycle response.
//   state     | meaning
//   IDLE      | accepting commands
//   SIFT_UP   | moving the last pushed element toward the root
//   SIFT_DOWN | moving the relocated root toward the leaves after a pop
module heap_pq_unit
    import heap_pq_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int DEPTH    = 32,
    parameter int MIN_HEAP = 0,
    parameter int CNT_W    = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_v,
    output logic              in_ready,
    input  logic [1:0]        in_op,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_v,
    output logic [DATA_W-1:0] out_data,
    output logic              out_err,
    output logic [CNT_W-1:0]  count,
    output logic              empty,
    output logic              full
);

    localparam int IDX_W  = CNT_W + 1;
    localparam int ADDR_W = $clog2(DEPTH);

    state_t state, next_state;

    logic [DATA_W-1:0] heap [DEPTH];
    logic [IDX_W-1:0]  idx, parent, left, right, best_l, best, cnt_x;
    logic [DATA_W-1:0] d_idx, d_par, d_left, d_right, d_best_l, d_best;
    logic              up_wins, left_wins, right_wins, left_ok, right_ok;
    logic              accept, swap_up, swap_down;
    logic [ADDR_W-1:0] wr_addr, last_addr;

    assign in_ready = (state == IDLE);
    assign accept   = in_v && in_ready;
    assign empty    = (count == '0);
    assign full     = (count == CNT_W'(DEPTH));

    assign cnt_x     = IDX_W'(count);
    assign wr_addr   = count[ADDR_W-1:0];
    assign last_addr = ADDR_W'(count - CNT_W'(1));

    // Child/parent indices carry one spare bit so 2*idx+2 never wraps.
    assign parent   = (idx - IDX_W'(1)) >> 1;
    assign left     = (idx << 1) + IDX_W'(1);
    assign right    = (idx << 1) + IDX_W'(2);
    assign left_ok  = (left < cnt_x);
    assign right_ok = (right < cnt_x);

    assign d_idx   = heap[idx[ADDR_W-1:0]];
    assign d_par   = heap[parent[ADDR_W-1:0]];
    assign d_left  = heap[left[ADDR_W-1:0]];
    assign d_right = heap[right[ADDR_W-1:0]];

    heap_pq_cmp #(.DATA_W(DATA_W), .MIN_HEAP(MIN_HEAP)) u_cmp_up (
        .a(d_idx), .b(d_par), .a_wins(up_wins)
    );

    heap_pq_cmp #(.DATA_W(DATA_W), .MIN_HEAP(MIN_HEAP)) u_cmp_left (
        .a(d_left), .b(d_idx), .a_wins(left_wins)
    );

    // Right must strictly beat the current best, so a child tie keeps the left one.
    assign best_l   = (left_ok && left_wins) ? left : idx;
    assign d_best_l = (left_ok && left_wins) ? d_left : d_idx;

    heap_pq_cmp #(.DATA_W(DATA_W), .MIN_HEAP(MIN_HEAP)) u_cmp_right (
        .a(d_right), .b(d_best_l), .a_wins(right_wins)
    );

    assign best   = (right_ok && right_wins) ? right : best_l;
    assign d_best = (right_ok && right_wins) ? d_right : d_best_l;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= next_state;
    end

    always_comb begin
        next_state = state;
        swap_up    = 1'b0;
        swap_down  = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (in_op == OP_PUSH && !full)
                        next_state = SIFT_UP;
                    else if (in_op == OP_POP && count > CNT_W'(2))
                        next_state = SIFT_DOWN;
                end
            end
            SIFT_UP: begin
                if (idx != '0 && up_wins) swap_up = 1'b1;
                else                      next_state = IDLE;
            end
            SIFT_DOWN: begin
                if (best != idx) swap_down = 1'b1;
                else             next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    // Storage is deliberately left out of reset; only count marks valid entries.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count    <= '0;
            idx      <= '0;
            out_v    <= 1'b0;
            out_data <= '0;
            out_err  <= 1'b0;
        end else begin
            out_v    <= accept;
            out_data <= '0;
            out_err  <= 1'b0;
            if (accept) begin
                case (in_op)
                    OP_PUSH: begin
                        if (full) begin
                            out_err <= 1'b1;
                        end else begin
                            heap[wr_addr] <= in_data;
                            count         <= count + CNT_W'(1);
                            idx           <= cnt_x;
                        end
                    end
                    OP_POP: begin
                        if (empty) begin
                            out_err <= 1'b1;
                        end else begin
                            out_data <= heap[0];
                            heap[0]  <= heap[last_addr];
                            count    <= count - CNT_W'(1);
                            idx      <= '0;
                        end
                    end
                    OP_PEEK: begin
                        if (empty) out_err  <= 1'b1;
                        else       out_data <= heap[0];
                    end
                    default: count <= '0;
                endcase
            end else if (swap_up) begin
                heap[idx[ADDR_W-1:0]]    <= d_par;
                heap[parent[ADDR_W-1:0]] <= d_idx;
                idx                      <= parent;
            end else if (swap_down) begin
                heap[idx[ADDR_W-1:0]]  <= d_best;
                heap[best[ADDR_W-1:0]] <= d_idx;
                idx                    <= best;
            end
        end
    end

endmodule
